// File: rtl/mutex_requester.sv
// Clocked 4-phase req/grant client for one side of an asynchronous mutex element.
// start->req 1 cycle, gnt edge->state change SYNC_STAGES+1 cycles; no backpressure, start ignored while busy.
module mutex_requester #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_W      = 8,
  parameter int TIMEOUT_W   = 12,
  parameter int CNT_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [HOLD_W-1:0] hold_cycles_i,
  input  logic              gnt_i,
  output logic              req_o,
  output logic              busy_o,
  output logic              in_cs_o,
  output logic              done_o,
  output logic              timeout_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  txn_count_o
);

  typedef enum logic [2:0] {
    S_DRAIN,
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_REL
  } state_e;

  localparam int                   DRAIN_W   = $clog2(SYNC_STAGES + 2);
  localparam logic [DRAIN_W-1:0]   DRAIN_MIN = DRAIN_W'(SYNC_STAGES);
  localparam logic [TIMEOUT_W-1:0] WAIT_MAX  = '1;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   gnt_s;
  logic                   gnt_prev_q;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [TIMEOUT_W-1:0]   wait_q, wait_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [HOLD_W-1:0]      hcnt_q, hcnt_d;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   tmo_q, tmo_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       txn_q, txn_d;
  logic                   accept;

  assign gnt_s  = sync_q[SYNC_STAGES-1];
  assign accept = (state_q == S_IDLE) && start_i && !gnt_s;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      gnt_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], gnt_i};
      gnt_prev_q <= gnt_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_DRAIN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DRAIN: if (drain_q >= DRAIN_MIN && !gnt_s) state_d = S_IDLE;
      S_IDLE:  if (accept)                         state_d = S_REQ;
      S_REQ:   if (gnt_s)                          state_d = S_HOLD;
      S_HOLD:  if (hcnt_q == hold_q - HOLD_W'(1))  state_d = S_REL;
      S_REL:   if (!gnt_s)                         state_d = S_IDLE;
      default:                                     state_d = S_DRAIN;
    endcase
  end

  always_comb begin
    busy_o  = (state_q != S_IDLE);
    in_cs_o = (state_q == S_HOLD);
  end

  always_comb begin
    drain_d = drain_q;
    if (state_q == S_DRAIN && drain_q != DRAIN_MIN) drain_d = drain_q + DRAIN_W'(1);

    // The wait counter saturates; the request itself is never withdrawn.
    wait_d = '0;
    if (state_q == S_REQ && !gnt_s) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + TIMEOUT_W'(1);
    end

    hold_d = hold_q;
    if (accept) hold_d = (hold_cycles_i == '0) ? HOLD_W'(1) : hold_cycles_i;

    hcnt_d = (state_q == S_HOLD) ? hcnt_q + HOLD_W'(1) : '0;

    req_d  = (state_d == S_REQ) || (state_d == S_HOLD);
    done_d = (state_q == S_REL) && !gnt_s;
    tmo_d  = (state_q == S_REQ) && !gnt_s && (wait_q == WAIT_MAX - TIMEOUT_W'(1));
    err_d  = err_q
           | ((state_q == S_IDLE) &&  gnt_s && !gnt_prev_q)
           | ((state_q == S_HOLD) && !gnt_s &&  gnt_prev_q);
    txn_d  = done_d ? txn_q + CNT_W'(1) : txn_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drain_q <= '0;
      wait_q  <= '0;
      hold_q  <= HOLD_W'(1);
      hcnt_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      err_q   <= 1'b0;
      txn_q   <= '0;
    end else begin
      drain_q <= drain_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      txn_q   <= txn_d;
    end
  end

  assign req_o       = req_q;
  assign done_o      = done_q;
  assign timeout_o   = tmo_q;
  assign err_o       = err_q;
  assign txn_count_o = txn_q;

endmodule

// File: tb/tb_mutex_requester.sv
// Randomized scoreboard bench: two requesters, a follower grant source and a behavioural mutex.
`timescale 1ns/1ps
module tb_mutex_requester;
  localparam int SYNC    = 2;
  localparam int HW      = 8;
  localparam int TW      = 4;
  localparam int CW      = 16;
  localparam int TMO_CYC = (1 << TW) - 1;

  typedef struct packed {
    int hold;
    int txn;
    bit err;
    int tmo;   // -1: timeout count not predicted
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start [2];
  logic [HW-1:0] hold  [2];
  logic          gnt   [2] = '{1'b0, 1'b0};
  logic          req   [2];
  logic          busy  [2];
  logic          in_cs [2];
  logic          done  [2];
  logic          tmo   [2];
  logic          err   [2];
  logic [CW-1:0] cnt   [2];

  mutex_requester #(.SYNC_STAGES(SYNC), .HOLD_W(HW), .TIMEOUT_W(TW), .CNT_W(CW)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .hold_cycles_i(hold[0]), .gnt_i(gnt[0]),
    .req_o(req[0]), .busy_o(busy[0]), .in_cs_o(in_cs[0]), .done_o(done[0]),
    .timeout_o(tmo[0]), .err_o(err[0]), .txn_count_o(cnt[0]));

  mutex_requester #(.SYNC_STAGES(SYNC), .HOLD_W(HW), .TIMEOUT_W(TW), .CNT_W(CW)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .hold_cycles_i(hold[1]), .gnt_i(gnt[1]),
    .req_o(req[1]), .busy_o(busy[1]), .in_cs_o(in_cs[1]), .done_o(done[1]),
    .timeout_o(tmo[1]), .err_o(err[1]), .txn_count_o(cnt[1]));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q  [2][$];
  int   rise_q [2][$];
  int   m_cnt  [2];
  bit   m_err  [2];

  task automatic chk(input string nm, input int k, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s[%0d] @cyc %0d: got %0d, expected %0d", nm, k, cyc, act, want);
    end
  endtask

  // Grant environment: mode 0 = A follows its own req with programmable delays, mode 1 = mutex between A and B.
  int mode    = 0;
  bit manual  = 1'b0;
  bit man_val = 1'b0;
  int d_up    = 3;
  int d_dn    = 3;
  bit g_f     = 1'b0;
  int up_cnt  = 0;
  int dn_cnt  = 0;
  bit mu_u    = 1'b0;
  bit mu_v    = 1'b0;

  always @(negedge clk) begin
    if (mode == 1) begin
      if (mu_u && !req[0]) mu_u = 1'b0;
      if (mu_v && !req[1]) mu_v = 1'b0;
      if (!mu_u && !mu_v) begin
        if (req[0] && req[1]) begin
          if ($urandom_range(1, 0) == 1) mu_u = 1'b1;
          else                           mu_v = 1'b1;
        end else if (req[0]) mu_u = 1'b1;
        else if (req[1])     mu_v = 1'b1;
      end
      gnt[0] = mu_u;
      gnt[1] = mu_v;
    end else begin
      if (manual) begin
        g_f = man_val; up_cnt = 0; dn_cnt = 0;
      end else if (req[0] && !g_f) begin
        up_cnt++;
        if (up_cnt >= d_up) begin g_f = 1'b1; up_cnt = 0; end
      end else if (!req[0] && g_f) begin
        dn_cnt++;
        if (dn_cnt >= d_dn) begin g_f = 1'b0; dn_cnt = 0; end
      end else begin
        up_cnt = 0; dn_cnt = 0;
      end
      gnt[0] = g_f;
      gnt[1] = 1'b0;
    end
  end

  int cs_cnt   [2] = '{0, 0};
  int tmo_cnt  [2] = '{0, 0};
  int rise_cyc [2] = '{0, 0};
  bit prev_req [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        cs_cnt[k] = 0; tmo_cnt[k] = 0; prev_req[k] = 1'b0;
      end else begin
        if (req[k] && !prev_req[k]) begin
          rise_cyc[k] = cyc;
          if (rise_q[k].size() == 0) chk("unexpected_req", k, 1, 0);
          else                       chk("req_latency", k, cyc, rise_q[k].pop_front());
        end
        if (in_cs[k]) cs_cnt[k]++;
        if (tmo[k]) begin
          tmo_cnt[k]++;
          chk("tmo_latency", k, cyc - rise_cyc[k], TMO_CYC);
          chk("req_held_at_tmo", k, int'(req[k]), 1);
        end
        if (done[k]) begin
          if (exp_q[k].size() == 0) chk("unexpected_done", k, 1, 0);
          else begin
            e = exp_q[k].pop_front();
            chk("cs_len", k, cs_cnt[k], e.hold);
            chk("txn_count", k, int'(cnt[k]), e.txn);
            chk("err", k, int'(err[k]), int'(e.err));
            if (e.tmo >= 0) chk("tmo_count", k, tmo_cnt[k], e.tmo);
          end
          cs_cnt[k] = 0; tmo_cnt[k] = 0;
        end
        prev_req[k] = req[k];
      end
    end
    if (mode == 1 && !rst && (in_cs[0] || in_cs[1]))
      chk("mutual_excl", 0, int'(in_cs[0] && in_cs[1]), 0);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input int k);
    int b = 0;
    while (busy[k] !== 1'b0 && b < 2000) begin
      @(negedge clk); b++;
    end
    chk("idle_wait", k, int'(busy[k] !== 1'b0), 0);
  endtask

  task automatic arm(input int k, input int h, input int tmo_exp);
    exp_t e;
    start[k] = 1'b1;
    hold[k]  = HW'(h);
    m_cnt[k] = (m_cnt[k] + 1) % (1 << CW);
    e.hold = (h == 0) ? 1 : h;
    e.txn  = m_cnt[k];
    e.err  = m_err[k];
    e.tmo  = tmo_exp;
    exp_q[k].push_back(e);
    rise_q[k].push_back(cyc + 1);
  endtask

  // Grant reaches the FSM SYNC_STAGES+1 edges after the follower raises it, so REQ lasts du+SYNC cycles.
  task automatic txn_follow(input int h, input int du, input int dd);
    wait_idle(0);
    d_up = du;
    d_dn = dd;
    arm(0, h, (du + SYNC > TMO_CYC) ? 1 : 0);
    tick();
    start[0] = 1'b0;
    hold[0]  = HW'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete(); rise_q[k].delete(); m_cnt[k] = 0; m_err[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_req", k, int'(req[k]), 0);
      chk("rst_busy", k, int'(busy[k]), 1);
      chk("rst_in_cs", k, int'(in_cs[k]), 0);
      chk("rst_done", k, int'(done[k]), 0);
      chk("rst_timeout", k, int'(tmo[k]), 0);
      chk("rst_err", k, int'(err[k]), 0);
      chk("rst_txn_count", k, int'(cnt[k]), 0);
    end
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1);
  end

  initial begin
    int b;
    start[0] = 1'b0; start[1] = 1'b0;
    hold[0]  = '0;   hold[1]  = '0;
    tick();
    do_reset();

    txn_follow(3, 3, 3);
    txn_follow(0, 2, 1);
    txn_follow(2, 40, 2);
    txn_follow(1, TMO_CYC - SYNC, 1);
    txn_follow(1, TMO_CYC - SYNC + 1, 1);
    repeat (30) txn_follow($urandom_range(12, 0), $urandom_range(20, 1), $urandom_range(5, 1));

    // Grant pulse while idle: start during it must be ignored and err must latch.
    wait_idle(0);
    tick(2);
    manual = 1'b1; man_val = 1'b1; m_err[0] = 1'b1;
    tick(3); start[0] = 1'b1; hold[0] = HW'(5);
    tick(3); man_val = 1'b0;
    tick(1); start[0] = 1'b0;
    tick(6);
    chk("start_ignored_gnt", 0, int'(busy[0]), 0);
    chk("err_set", 0, int'(err[0]), 1);
    manual = 1'b0;
    repeat (3) txn_follow($urandom_range(8, 0), $urandom_range(6, 1), $urandom_range(3, 1));

    // Reset in the middle of HOLD with the grant still high.
    wait_idle(0);
    d_up = 2; d_dn = 2;
    arm(0, 50, 0);
    tick();
    start[0] = 1'b0;
    b = 0;
    while (in_cs[0] !== 1'b1 && b < 100) begin tick(); b++; end
    chk("reach_hold", 0, int'(in_cs[0]), 1);
    tick(3);
    manual = 1'b1; man_val = 1'b1;
    do_reset();
    start[0] = 1'b1; hold[0] = HW'(4);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 2) man_val = 1'b0;
      chk("drain_busy", 0, int'(busy[0]), 1);
      chk("drain_req", 0, int'(req[0]), 0);
    end
    start[0] = 1'b0;
    wait_idle(0);
    tick(3);
    chk("drain_start_ignored", 0, int'(req[0]), 0);
    manual = 1'b0;
    repeat (2) txn_follow($urandom_range(8, 0), $urandom_range(6, 1), $urandom_range(3, 1));

    // Two requesters contending for one mutex.
    wait_idle(0);
    tick(4);
    do_reset();
    mode = 1;
    repeat (100) begin
      wait_idle(0);
      wait_idle(1);
      arm(0, $urandom_range(15, 0), -1);
      arm(1, $urandom_range(15, 0), -1);
      tick();
      start[0] = 1'b0; start[1] = 1'b0;
      hold[0]  = HW'($urandom); hold[1] = HW'($urandom);
    end
    wait_idle(0);
    wait_idle(1);
    tick(3);
    chk("txn_sum", 0, int'(cnt[0]) + int'(cnt[1]), 200);
    chk("sb_empty", 0, exp_q[0].size() + rise_q[0].size(), 0);
    chk("sb_empty", 1, exp_q[1].size() + rise_q[1].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
